// File: rtl/adder_result_collector.sv
// rtl/adder_result_collector.sv - result FIFO and golden self-check behind the 4-bit ripple-carry adder (checker enabled by ADDER_RESULT_CHECK_EN)
module adder_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic             Cin,
  input  logic [3:0]       Sum,
  input  logic             Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [8:0]       first_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [4:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  // Handshakes depend only on registered occupancy, so no input-to-output paths exist.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Head is masked when empty so the output reads zero in and right after reset.
  assign out_data  = out_valid ? mem[rd_ptr] : 5'd0;

  // Record storage; contents need no reset because out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {Sum, Cout};
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ADDER_RESULT_CHECK_EN
  logic [4:0] golden;
  logic       match;

  assign golden = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
  assign match  = (golden == {Cout, Sum});

  // Score each push against the golden sum; first mismatch operands are latched once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      first_err <= '0;
    end else if (push) begin
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!err) begin
          err       <= 1'b1;
          first_err <= {A, B, Cin};
        end
      end
    end
  end
`else
  logic unused_operands;

  assign unused_operands = ^{A, B, Cin};
  assign fail_cnt        = '0;
  assign err             = 1'b0;
  assign first_err       = '0;

  // Without the checker every push is counted as a pass, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
    end else if (push && (pass_cnt != '1)) begin
      pass_cnt <= pass_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// tb/tb_adder_result_collector.sv - scoreboard bench for adder_result_collector
module tb_adder_result_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, sum;
  logic       cin, cout;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [7:0] pass_cnt, fail_cnt;
  logic       err;
  logic [8:0] first_err;

  logic       s_valid, s_in_ready, s_out_valid, s_err;
  logic [3:0] s_a, s_sum;
  logic [4:0] s_out_data;
  logic [2:0] s_pass_cnt, s_fail_cnt;
  logic [8:0] s_first_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] exp_q[$];
  int         exp_pass  = 0;
  int         exp_fail  = 0;
  logic       exp_err   = 1'b0;
  logic [8:0] exp_first = '0;

  always #5 clk = ~clk;

  adder_result_collector #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sum(sum), .Cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .first_err(first_err)
  );

  adder_result_collector #(.DEPTH(4), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready),
    .A(s_a), .B(4'h0), .Cin(1'b0), .Sum(s_sum), .Cout(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .err(s_err), .first_err(s_first_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any pop the DUT will take at the next edge must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %b with empty scoreboard", out_data);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %b expected %b", out_data, e);
        end
      end
    end
  end

  task automatic model_push(input bit good, input logic [8:0] tag);
`ifdef ADDER_RESULT_CHECK_EN
    if (good) begin
      if (exp_pass != 255) exp_pass++;
    end else begin
      if (exp_fail != 255) exp_fail++;
      if (!exp_err) begin
        exp_err   = 1'b1;
        exp_first = tag;
      end
    end
`else
    if (exp_pass != 255) exp_pass++;
`endif
  endtask

  // Called at posedge+1; presents one beat and returns at the next posedge+1.
  task automatic push(input logic [3:0] pa, input logic [3:0] pb, input logic pc,
                      input logic [3:0] ps, input logic pco, input bit good);
    a = pa; b = pb; cin = pc; sum = ps; cout = pco; in_valid = 1'b1;
    if (in_ready) begin
      exp_q.push_back({ps, pco});
      model_push(good, {pa, pb, pc});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pass"}, 32'(pass_cnt), 32'(exp_pass));
    check({tag, "_fail"}, 32'(fail_cnt), 32'(exp_fail));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_first"}, 32'(first_err), 32'(exp_first));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
    s_valid = 1'b0; s_a = '0; s_sum = '0;
    idle(2);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check_counters("rst");
    rst = 1'b0;
    idle(1);

    // Correct stream plus first-push latency
    out_ready = 1'b1;
    check("empty_out_valid", 32'(out_valid), 0);
    push(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
    check("latency_out_valid", 32'(out_valid), 1);
    check("latency_out_data", 32'(out_data), 32'b00001);
    push(4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1);
    idle(3);
    check_counters("good");

    // Two mismatches: first_err keeps the first one
    push(4'b0010, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);
    push(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(3);
    check_counters("bad");
`ifdef ADDER_RESULT_CHECK_EN
    check("bad_first_literal", 32'(first_err), 32'b0010_0010_0);
`endif

    // Full: fifth push is refused while out_ready is low
    out_ready = 1'b0;
    push(4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b1);
    push(4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1);
    push(4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1);
    check("full_not_yet", 32'(in_ready), 1);
    push(4'h9, 4'h9, 1'b0, 4'h2, 1'b1, 1'b1);
    check("full_in_ready", 32'(in_ready), 0);
    push(4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);
    check("full_count", 32'(u_dut.count), 4);
    check("full_queued", exp_q.size(), 4);
    check("full_head_stable", 32'(out_data), 32'b00110);
    out_ready = 1'b1;
    idle(6);
    check("full_drained", exp_q.size(), 0);
    check("full_empty", 32'(out_valid), 0);

    // Simultaneous push and pop with two entries resident
    out_ready = 1'b0;
    push(4'hA, 4'h1, 1'b0, 4'hB, 1'b0, 1'b1);
    push(4'hC, 4'hC, 1'b1, 4'h9, 1'b1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [4:0] g;
      g = 5'(i) + 5'((i + 3) % 16) + 5'(i & 1);
      push(4'(i), 4'((i + 3) % 16), 1'(i & 1), g[3:0], g[4], 1'b1);
      check("simul_count", 32'(u_dut.count), 2);
    end
    idle(4);
    check("simul_drained", exp_q.size(), 0);
    check_counters("simul");

    // Asynchronous reset mid-stream with three entries queued
    out_ready = 1'b0;
    push(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b1);
    push(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b1);
    push(4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_pass = 0; exp_fail = 0; exp_err = 1'b0; exp_first = '0;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_out_data", 32'(out_data), 0);
    check_counters("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    out_ready = 1'b1;
    push(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b1);
    check("post_rst_data", 32'(out_data), 32'b00100);
    idle(3);
    check("post_rst_drained", exp_q.size(), 0);
    check_counters("post_rst");

    // Saturation on the 3-bit counter instance
    for (int i = 0; i < 9; i++) begin
      s_a = 4'(i); s_sum = 4'(i); s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("sat_pass", 32'(s_pass_cnt), 7);
    check("sat_fail", 32'(s_fail_cnt), 0);
    idle(2);
    check("sat_hold", 32'(s_pass_cnt), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
